// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shifter (LSL/LSR/ASR/ROR) producing ARM result and carry-out, STEP bits per cycle.
// Optional build macro SHIFT_SEQ_RRX_EN: ROR by zero performs RRX in a single SHIFT cycle.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  shiftType,
    input  logic [7:0]  shiftAmt,
    input  logic [31:0] rmData,
    input  logic        carryIn,
    output logic        busy,
    output logic        done,
    output logic [31:0] shiftedData,
    output logic        carryOut
);

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam logic [5:0] STEP_W = 6'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_reg;
    logic [31:0] work_reg;
    logic        carry_reg;
    logic [1:0]  type_reg;
    logic [5:0]  count_reg;
`ifdef SHIFT_SEQ_RRX_EN
    logic        rrx_reg;
    logic        start_rrx;
`endif

    logic [5:0]  start_count;
    logic [5:0]  step_n;
    logic [4:0]  lsl_idx;
    logic [4:0]  low_idx;
    logic [31:0] step_data;
    logic        step_carry;

    // Capping at 33 makes every out-of-range amount land on ARM's "shift everything out" result.
    always_comb begin
        start_count = '0;
`ifdef SHIFT_SEQ_RRX_EN
        start_rrx = 1'b0;
`endif
        if (shiftType == ROR) begin
            if (shiftAmt == 8'd0) begin
`ifdef SHIFT_SEQ_RRX_EN
                start_count = 6'd1;
                start_rrx   = 1'b1;
`else
                start_count = 6'd0;
`endif
            end else if (shiftAmt[4:0] == 5'd0) begin
                start_count = 6'd32;
            end else begin
                start_count = {1'b0, shiftAmt[4:0]};
            end
        end else if (shiftAmt > 8'd33) begin
            start_count = 6'd33;
        end else begin
            start_count = shiftAmt[5:0];
        end
    end

    always_comb begin
        step_n     = (count_reg < STEP_W) ? count_reg : STEP_W;
        lsl_idx    = 5'(6'd32 - step_n);
        low_idx    = 5'(step_n - 6'd1);
        step_data  = work_reg;
        step_carry = carry_reg;
        case (type_reg)
            LSL: begin
                step_data  = work_reg << step_n;
                step_carry = work_reg[lsl_idx];
            end
            LSR: begin
                step_data  = work_reg >> step_n;
                step_carry = work_reg[low_idx];
            end
            ASR: begin
                step_data  = 32'($signed(work_reg) >>> step_n);
                step_carry = work_reg[low_idx];
            end
            default: begin
                step_data  = (work_reg >> step_n) | (work_reg << (6'd32 - step_n));
                step_carry = work_reg[low_idx];
            end
        endcase
`ifdef SHIFT_SEQ_RRX_EN
        // RRX rotates the latched C flag in at the top.
        if (rrx_reg) begin
            step_data  = {carry_reg, work_reg[31:1]};
            step_carry = work_reg[0];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            work_reg    <= '0;
            carry_reg   <= 1'b0;
            type_reg    <= LSL;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shiftedData <= '0;
            carryOut    <= 1'b0;
`ifdef SHIFT_SEQ_RRX_EN
            rrx_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work_reg  <= rmData;
                        carry_reg <= carryIn;
                        type_reg  <= shiftType;
                        count_reg <= start_count;
                        busy      <= 1'b1;
`ifdef SHIFT_SEQ_RRX_EN
                        rrx_reg   <= start_rrx;
`endif
                        if (start_count == 6'd0) begin
                            state_reg   <= DONE;
                            done        <= 1'b1;
                            shiftedData <= rmData;
                            carryOut    <= carryIn;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_reg  <= step_data;
                    carry_reg <= step_carry;
                    count_reg <= count_reg - step_n;
                    if (count_reg == step_n) begin
                        state_reg   <= DONE;
                        done        <= 1'b1;
                        shiftedData <= step_data;
                        carryOut    <= step_carry;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and table-driven bench for shift_sequencer with a queue scoreboard of ARM-semantics expectations.
module tb_shift_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  shiftType;
    logic [7:0]  shiftAmt;
    logic [31:0] rmData;
    logic        carryIn;
    logic        busy;
    logic        done;
    logic [31:0] shiftedData;
    logic        carryOut;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        int          lat;
    } exp_t;

    exp_t sb[$];

    shift_sequencer #(.STEP(STEP)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .shiftType(shiftType),
        .shiftAmt(shiftAmt),
        .rmData(rmData),
        .carryIn(carryIn),
        .busy(busy),
        .done(done),
        .shiftedData(shiftedData),
        .carryOut(carryOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ARM shifter-operand semantics written directly from the architectural rules.
    function automatic exp_t model(input logic [1:0] t, input logic [7:0] amt,
                                   input logic [31:0] rm, input logic cin);
        exp_t e;
        int a;
        int r;
        int c;
        a = int'(amt);
        r = a % 32;
        c = 0;
        e.data = rm;
        e.carry = cin;
        case (t)
            2'b00, 2'b01: begin
                c = (a > 33) ? 33 : a;
                if (a != 0) begin
                    e.data = 32'h0;
                    if (a < 32) begin
                        e.data  = (t == 2'b00) ? (rm << a) : (rm >> a);
                        e.carry = (t == 2'b00) ? rm[32 - a] : rm[a - 1];
                    end else if (a == 32) begin
                        e.carry = (t == 2'b00) ? rm[0] : rm[31];
                    end else begin
                        e.carry = 1'b0;
                    end
                end
            end
            2'b10: begin
                c = (a > 33) ? 33 : a;
                if (a != 0) begin
                    if (a < 32) begin
                        e.data  = 32'($signed(rm) >>> a);
                        e.carry = rm[a - 1];
                    end else begin
                        e.data  = {32{rm[31]}};
                        e.carry = rm[31];
                    end
                end
            end
            default: begin
                if (a == 0) begin
`ifdef SHIFT_SEQ_RRX_EN
                    e.data  = {cin, rm[31:1]};
                    e.carry = rm[0];
                    c = 1;
`endif
                end else if (r == 0) begin
                    c = 32;
                    e.carry = rm[31];
                end else begin
                    c = r;
                    e.data  = (rm >> r) | (rm << (32 - r));
                    e.carry = rm[r - 1];
                end
            end
        endcase
        e.lat = (c == 0) ? 1 : (c + STEP - 1) / STEP + 1;
        return e;
    endfunction

    // Called just after the accept edge (or later, with first_lat = cycle index of next sample).
    task automatic wait_done(input string tag, input int first_lat);
        exp_t e;
        int lat;
        logic [31:0] held_data;
        logic held_c;
        lat = first_lat;
        @(negedge clk);
        while (!done && lat < 100) begin
            check({tag, " busy"}, {31'b0, busy}, 32'd1);
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL %s timeout: observed no done expected done within 100 cycles", tag);
            return;
        end
        e = sb.pop_front();
        $display("[TB] %s: data=%h c=%b latency=%0d", tag, shiftedData, carryOut, lat);
        check({tag, " data"}, shiftedData, e.data);
        check({tag, " carry"}, {31'b0, carryOut}, {31'b0, e.carry});
        check({tag, " latency"}, lat, e.lat);
        check({tag, " busy@done"}, {31'b0, busy}, 32'd1);
        held_data = shiftedData;
        held_c = carryOut;
        @(negedge clk);
        check({tag, " done pulse"}, {31'b0, done}, 32'd0);
        check({tag, " busy idle"}, {31'b0, busy}, 32'd0);
        check({tag, " hold"}, {shiftedData[30:0], carryOut}, {held_data[30:0], held_c});
    endtask

    task automatic issue(input logic [1:0] t, input logic [7:0] amt,
                         input logic [31:0] rm, input logic cin);
        @(negedge clk);
        shiftType = t;
        shiftAmt  = amt;
        rmData    = rm;
        carryIn   = cin;
        start     = 1'b1;
        sb.push_back(model(t, amt, rm, cin));
        @(posedge clk);
        #1;
        // Scramble inputs: the in-flight operation must not see them.
        start     = 1'b0;
        rmData    = ~rm;
        carryIn   = ~cin;
        shiftAmt  = 8'($urandom);
        shiftType = 2'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [1:0] t, input logic [7:0] amt,
                          input logic [31:0] rm, input logic cin);
        issue(t, amt, rm, cin);
        wait_done(tag, 1);
    endtask

    initial begin
        logic [7:0] amts[12];
        reset = 1'b1;
        start = 1'b0;
        shiftType = 2'b00;
        shiftAmt = 8'd0;
        rmData = 32'h0;
        carryIn = 1'b0;
        amts = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd31, 8'd32, 8'd33, 8'd34, 8'd63, 8'd64, 8'd255};

        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset data", shiftedData, 32'd0);
        check("reset carry", {31'b0, carryOut}, 32'd0);
        reset = 1'b0;

        run_op("lsl1", 2'b00, 8'd1, 32'h80000001, 1'b0);
        run_op("lsr40", 2'b01, 8'd40, 32'hFFFFFFFF, 1'b1);
        run_op("asr32 neg", 2'b10, 8'd32, 32'h80000000, 1'b0);
        run_op("asr32 pos", 2'b10, 8'd32, 32'h40000000, 1'b1);
        run_op("ror36", 2'b11, 8'd36, 32'h000000F8, 1'b0);
        run_op("ror32", 2'b11, 8'd32, 32'h12345678, 1'b1);
        run_op("lsr0", 2'b01, 8'd0, 32'hDEADBEEF, 1'b1);
        run_op("ror0", 2'b11, 8'd0, 32'h00000003, 1'b1);
        run_op("lsl32", 2'b00, 8'd32, 32'h00000001, 1'b0);
        run_op("lsr32", 2'b01, 8'd32, 32'h80000000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_op("table", 2'($urandom_range(0, 3)), amts[$urandom_range(0, 11)],
                   $urandom, 1'($urandom));
        end

        // Start during busy is ignored, not queued.
        issue(2'b00, 8'd33, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        shiftType = 2'b11;
        shiftAmt  = 8'd4;
        rmData    = 32'h0000000F;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("lsl33 ignore", 3);
        repeat (3) begin
            @(negedge clk);
            check("no queued op", {30'b0, busy, done}, 32'd0);
        end

        // Asynchronous reset mid-operation.
        run_op("pre reset", 2'b01, 8'd0, 32'h12345678, 1'b1);
        @(negedge clk);
        shiftType = 2'b00;
        shiftAmt  = 8'd33;
        rmData    = 32'hFFFFFFFF;
        carryIn   = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy before reset", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async rst busy", {31'b0, busy}, 32'd0);
        check("async rst done", {31'b0, done}, 32'd0);
        check("async rst data", shiftedData, 32'd0);
        check("async rst carry", {31'b0, carryOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post reset", 2'b10, 8'd4, 32'h80000010, 1'b0);

        check("scoreboard empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
